// File: rtl/snd_pkg.sv
// Shared widths and bit mapping for the 1-bit sound link (generator and demodulator).
package snd_pkg;

  // Bitstream symbol values as 2-bit signed, sign-extended by the user.
  localparam logic signed [1:0] SND_P1 = 2'sb01;
  localparam logic signed [1:0] SND_M1 = 2'sb11;

  function automatic int cic_gain_bits(input int order, input int log2_decim);
    return order * log2_decim;
  endfunction

  function automatic int cic_width(input int order, input int log2_decim);
    return order * log2_decim + 2;
  endfunction

endpackage

// File: rtl/snd_cic_integrator.sv
// One CIC integrator stage: registered accumulator, wraps modulo 2^W by design.
module snd_cic_integrator #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc <= '0;
    else       acc <= acc + din;
  end

endmodule

// File: rtl/snd_demod.sv
// CIC decimator that turns the 1-bit snd stream back into saturated signed PCM.
module snd_demod
  import snd_pkg::*;
#(
  parameter int ORDER      = 3,
  parameter int LOG2_DECIM = 8,
  parameter int OUT_BITS   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                snd,
  output logic [OUT_BITS-1:0] pcm,
  output logic                pcm_valid,
  output logic                primed
);

  localparam int G     = cic_gain_bits(ORDER, LOG2_DECIM);
  localparam int W     = cic_width(ORDER, LOG2_DECIM);
  localparam int SHIFT = G + 1 - OUT_BITS;

  localparam logic signed [W-1:0] POS_LIM = {2'b00, {G{1'b1}}};
  localparam logic signed [W-1:0] NEG_LIM = {2'b11, {G{1'b0}}};

  logic                       snd_q;
  logic signed [1:0]          step;
  logic [W-1:0]               step_w;
  logic [ORDER-1:0][W-1:0]    acc;
  logic [LOG2_DECIM-1:0]      cnt;
  logic                       strobe;
  logic [ORDER-1:0][W-1:0]    comb_d;
  logic [ORDER:0][W-1:0]      comb_x;
  logic signed [W-1:0]        y;
  logic signed [W-1:0]        y_sat;
  logic [OUT_BITS-1:0]        pcm_next;
  logic [2:0]                 prime_cnt;
  logic                       emit;
  logic                       unused_sat;

  assign step   = snd_q ? SND_P1 : SND_M1;
  assign step_w = {{(W-2){step[1]}}, step};

  for (genvar k = 0; k < ORDER; k++) begin : g_int
    if (k == 0) begin : g_first
      snd_cic_integrator #(.W(W)) u_int (
        .clk(clk), .reset(reset), .din(step_w), .acc(acc[k])
      );
    end else begin : g_next
      snd_cic_integrator #(.W(W)) u_int (
        .clk(clk), .reset(reset), .din(acc[k-1]), .acc(acc[k])
      );
    end
  end

  assign strobe = (cnt == '1);

  // Comb chain settles within the strobe cycle; delays only advance on strobe.
  always_comb begin
    comb_x    = '0;
    comb_x[0] = acc[ORDER-1];
    for (int k = 0; k < ORDER; k++) comb_x[k+1] = comb_x[k] - comb_d[k];
  end

  always_comb begin
    y     = signed'(comb_x[ORDER]);
    y_sat = y;
    if (y > POS_LIM)      y_sat = POS_LIM;
    else if (y < NEG_LIM) y_sat = NEG_LIM;
  end

  // y_sat fits in G+1 bits, so this slice is the arithmetic shift by SHIFT.
  assign pcm_next   = y_sat[SHIFT +: OUT_BITS];
  assign unused_sat = ^y_sat;

  assign emit = strobe && (prime_cnt == 3'(ORDER));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snd_q     <= 1'b0;
      cnt       <= '0;
      comb_d    <= '0;
      prime_cnt <= '0;
      pcm       <= '0;
      pcm_valid <= 1'b0;
      primed    <= 1'b0;
    end else begin
      snd_q     <= snd;
      cnt       <= cnt + 1'b1;
      pcm_valid <= emit;
      if (strobe) begin
        comb_d <= comb_x[ORDER-1:0];
        if (!emit) prime_cnt <= prime_cnt + 3'd1;
      end
      if (emit) begin
        pcm    <= pcm_next;
        primed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snd_demod.sv
// Directed/random bench for snd_demod against an FIR-form CIC reference model.
module tb_snd_demod;

  localparam int N   = 3;
  localparam int LR  = 8;
  localparam int OB  = 16;
  localparam int R   = 1 << LR;
  localparam int G   = N * LR;
  localparam int L   = N * (R - 1) + 1;
  localparam int SH  = G + 1 - OB;
  localparam int XSZ = 8192;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          snd = 1'b0;
  logic [OB-1:0] pcm;
  logic          pcm_valid;
  logic          primed;

  snd_demod #(.ORDER(N), .LOG2_DECIM(LR), .OUT_BITS(OB)) dut (
    .clk(clk), .reset(reset), .snd(snd),
    .pcm(pcm), .pcm_valid(pcm_valid), .primed(primed)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  longint        h[L];
  int            xs[XSZ];
  int            e;
  logic [OB-1:0] pcm_hold;
  logic [15:0]   cexp[5] = '{16'h7FFF, 16'h8000, 16'h0000, 16'hC000, 16'h4000};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ideal CIC: impulse response convolved with the +/-1 input history.
  function automatic logic [OB-1:0] ref_pcm(input int en);
    longint y, hi, lo;
    y  = 0;
    hi = (longint'(1) <<< G) - 1;
    lo = -(longint'(1) <<< G);
    for (int j = 0; j < L; j++)
      if (en - N - j >= 1) y += h[j] * longint'(xs[en - N - j]);
    if (y > hi)      y = hi;
    else if (y < lo) y = lo;
    y = y >>> SH;
    return y[OB-1:0];
  endfunction

  function automatic void init_model();
    foreach (xs[i]) xs[i] = 0;
    xs[1]    = -1;
    e        = 0;
    pcm_hold = '0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    snd   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pcm", pcm, 0);
    check("rst_valid", pcm_valid, 0);
    check("rst_primed", primed, 0);
    init_model();
    reset = 1'b0;
  endtask

  // mode 0:const1 1:const0 2:1010 3:1000 4:1110 5:random with duty%
  task automatic run(input int mode, input int ncyc, input int duty);
    for (int c = 0; c < ncyc; c++) begin
      bit v;
      bit exp_v;
      case (mode)
        0:       v = 1'b1;
        1:       v = 1'b0;
        2:       v = (e % 2 == 0);
        3:       v = (e % 4 == 0);
        4:       v = (e % 4 != 3);
        default: v = ($urandom_range(99) < duty);
      endcase
      snd = v;
      if (e + 2 < XSZ) xs[e + 2] = v ? 1 : -1;
      @(posedge clk);
      e++;
      @(negedge clk);
      exp_v = (e % R == 0) && (e >= (N + 1) * R);
      check("valid", pcm_valid, exp_v);
      check("primed", primed, e >= (N + 1) * R);
      if (exp_v) begin
        pcm_hold = ref_pcm(e);
        if (mode <= 4) check("pcm_const", pcm, cexp[mode]);
      end
      check("pcm", pcm, pcm_hold);
    end
  endtask

  initial begin
    longint tmp[L];
    int len;
    foreach (h[i]) h[i] = 0;
    h[0] = 1;
    len  = 1;
    repeat (N) begin
      foreach (tmp[i]) tmp[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < R; j++) tmp[i + j] += h[i];
      len += R - 1;
      h = tmp;
    end

    for (int m = 0; m < 5; m++) begin
      do_reset();
      run(m, 7 * R, 0);
    end

    do_reset();
    run(5, 14 * R, 50);
    do_reset();
    run(5, 10 * R, 8);
    do_reset();
    run(5, 10 * R, 93);
    do_reset();
    run(5, 8 * R, 100);

    // Asynchronous reset between edges while primed and running.
    do_reset();
    run(5, 2000, 70);
    #2 reset = 1'b1;
    #1;
    check("async_pcm", pcm, 0);
    check("async_valid", pcm_valid, 0);
    check("async_primed", primed, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    init_model();
    reset = 1'b0;
    run(5, 6 * R, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snd_demod.md
# snd_demod

Recovers signed PCM samples from the 1-bit `snd` stream produced by `logistic_snd`: the receiving end of the bitstream audio link. A CIC decimator (ORDER integrators at clock rate, decimation by 2^LOG2_DECIM, ORDER combs at output rate) filters the bitstream, then saturates and scales the result to OUT_BITS with a one-cycle valid strobe. Used in audio-test benches and on-chip loopback, to check the generator's output numerically instead of by listening.

## Interface
- ORDER, 3: CIC order, legal 1..4.
- LOG2_DECIM, 8: decimation ratio R = 2^LOG2_DECIM, legal 3..10.
- OUT_BITS, 16: PCM output width, must be ≤ ORDER*LOG2_DECIM+1.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- snd  in  1  bitstream, sampled every clk; 1 → +1, 0 → −1.
- pcm  out  OUT_BITS  signed two's-complement sample; held between strobes.
- pcm_valid  out  1  one-cycle pulse when `pcm` updates.
- primed  out  1  high once the filter history is fully populated; stays high until reset.

## Operation
- Constants: G = ORDER*LOG2_DECIM (filter gain bits); W = G+2 (internal width).
- Input stage: `snd` is registered once into `snd_q`. The integrator input is +1 or −1 from `snd_q`, sign-extended to W.
- Integrators:
  - ORDER cascaded W-bit accumulators, each registered.
  - Modulo-2^W wrap is intended: no saturation and no overflow detection in this stage.
- Decimation counter:
  - LOG2_DECIM bits, increments every clk and wraps.
  - `strobe` = (count == R−1).
- Combs, evaluated only on a `strobe` cycle:
  - Stage input chain starts from the last integrator value.
  - Each stage outputs x − d and then updates d ← x, with W-bit wrap arithmetic.
  - One delay register per stage, so the differential delay is 1.
  - The comb chain is combinational within the strobe cycle.
- Output formation, giving comb result y in [−2^G, +2^G]:
  - Clamp y to [−2^G, 2^G−1].
  - Arithmetic shift right by G+1−OUT_BITS.
  - Register the result into `pcm`.
- Priming: a 3-bit strobe counter suppresses `pcm_valid` for the first ORDER strobes after reset. `primed` rises together with the first emitted `pcm_valid`.
- Reset, including mid-operation reset:
  - `pcm`=0, `pcm_valid`=0, `primed`=0.
  - Integrators, comb delays, decimation counter, priming counter and `snd_q` all go to 0.
  - Operation restarts from count 0 on the first edge after deassertion.

## Timing
- Edge 1 is the first rising edge with reset low. It registers `snd_q` and sets count to 1.
- A strobe occurs every R cycles, when count = R−1. `pcm` and `pcm_valid` are registered at the following edge, so `pcm_valid` is high for exactly one cycle in every R.
- The first `pcm_valid` is at the (ORDER+1)-th strobe, i.e. (ORDER+1)*R cycles after reset release, ±1 edge of the registering latency.
- Input-to-output latency is 1 (`snd_q`) + ORDER (integrator pipeline) + 1 (`pcm` register) cycles. The decimation phase is added on top.
- For constant-duty input, every emitted sample equals its steady-state value exactly; there is no startup transient in emitted samples. This holds because the impulse length ORDER*(R−1)+1 fits inside the suppressed window.
- No backpressure: the consumer must take `pcm` while `pcm_valid` is high, or within R−1 cycles afterwards.

## Structure
- Shared package `snd_pkg` holds:
  - the G/W width functions (`cic_gain_bits`, `cic_width`);
  - the ±1 mapping constants;
  - shared with `logistic_snd` test infrastructure.
- Sub-module `snd_cic_integrator`: one W-bit registered accumulator with async reset. It is instantiated ORDER times via generate.
- Combs, clamp and counters live in `snd_demod`.

## Test plan
- Constant `snd`=1 at defaults → first `pcm_valid` 1024 cycles (±1) after reset release; every `pcm` = 0x7FFF (clamped from +2^24); `primed`=1.
- Constant `snd`=0 → every `pcm` = 0x8000 (−32768).
- Alternating 1,0,1,0 → every emitted `pcm` = 0x0000 (Nyquist zero, R even).
- Repeating 1,0,0,0 → every `pcm` = 0xC000 (−16384). Repeating 1,1,1,0 → 0x4000.
- `logistic_snd` output fed in for 10^6 cycles → `pcm_valid` spacing is exactly 256 cycles; no sample leaves [−32768, 32767]; integrator wrap causes no glitch (bench reference is a model with unbounded integers).
- Reset asserted mid-run, for 3 cycles asynchronously between edges → all outputs 0 immediately; `primed` drops; the next `pcm_valid` is again 1024 cycles after release.
